// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer and its entry FIFO.
package fetch_pkg;

  localparam int DEPTH_DEFAULT = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(
    input logic [31:0] pc_i,
    input logic [31:0] instr_i,
    input logic        fault_i
  );
    fetch_entry_t e;
    e.pc    = pc_i;
    e.instr = instr_i;
    e.fault = fault_i;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry FIFO of fetch_entry_t with synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty    = (count_q == CNT_ZERO);
  assign full     = (count_q == CNT_FULL);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop_s = pop && !empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push_s = push && (!full || do_pop_s);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= make_entry(32'h0000_0000, NOP_INSTR, 1'b0);
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: issues instruction-memory requests for pc and queues in-order responses for decode.
// Define FETCH_MISALIGN_CHECK_EN to turn misaligned pcs into fault entries instead of memory requests.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        instr_fault
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] aq_wr_q, aq_wr_d;
  logic [PW-1:0] aq_rd_q, aq_rd_d;
  logic [31:0]   aq_mem_q [DEPTH];
  logic [31:0]   aq_mem_d [DEPTH];
  logic          active_q, active_d;

  logic          slot_free_s;
  logic          issue_s;
  logic          rsp_s;
  logic          rsp_keep_s;
  logic          fault_push_s;
  logic          push_s;
  logic          pop_s;
  fetch_entry_t  push_data_s;
  fetch_entry_t  head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] occupancy_s;

  // Each in-flight request has a buffer slot reserved, so a response can always be written.
  assign slot_free_s = ({1'b0, outstanding_q} + {1'b0, occupancy_s}) < DEPTH_W;
  assign imem_addr   = pc;
  assign issue_s     = imem_req && imem_gnt;
  assign pc_advance  = issue_s || fault_push_s;
  assign rsp_s       = imem_rvalid && (outstanding_q != CNT_ZERO);
  assign rsp_keep_s  = rsp_s && !flush && (discard_q == CNT_ZERO) && (!fifo_full_s || pop_s);
  assign pop_s       = instr_valid && instr_ready;
  assign push_s      = rsp_keep_s || fault_push_s;
  assign push_data_s = fault_push_s ? make_entry(pc, NOP_INSTR, 1'b1)
                                    : make_entry(aq_mem_q[aq_rd_q], imem_rdata, 1'b0);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_s;
  logic stall_q, stall_d;

  assign misalign_s   = (pc[1:0] != 2'b00);
  // Faults wait for older responses to drain so the buffer stays in program order.
  assign fault_push_s = active_q && !flush && misalign_s && !stall_q && slot_free_s
                        && (outstanding_q == CNT_ZERO);
  assign imem_req     = active_q && !flush && !misalign_s && !stall_q && slot_free_s;

  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = 1'b0;
    end else if (fault_push_s) begin
      stall_d = 1'b1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign fault_push_s = 1'b0;
  assign imem_req     = active_q && !flush && slot_free_s;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (occupancy_s)
  );

  assign instr_valid = !fifo_empty_s;
  assign instr       = instr_valid ? head_s.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head_s.pc : 32'h0000_0000;
  // The fault bit is only ever set by the misaligned-pc path, so this is 0 in the default build.
  assign instr_fault = instr_valid && head_s.fault;

  always_comb begin
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    aq_wr_d       = aq_wr_q;
    aq_rd_d       = aq_rd_q;
    aq_mem_d      = aq_mem_q;
    active_d      = 1'b1;

    case ({issue_s, rsp_s})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase

    // Responses still in flight at a flush belong to the old path and must be dropped.
    if (flush) begin
      discard_d = outstanding_q - (rsp_s ? CNT_ONE : CNT_ZERO);
    end else if (rsp_s && (discard_q != CNT_ZERO)) begin
      discard_d = discard_q - CNT_ONE;
    end else begin
      discard_d = discard_q;
    end

    if (issue_s) begin
      aq_mem_d[aq_wr_q] = pc;
      aq_wr_d           = aq_wr_q + PTR_ONE;
    end else begin
      aq_wr_d = aq_wr_q;
    end

    if (rsp_s) begin
      aq_rd_d = aq_rd_q + PTR_ONE;
    end else begin
      aq_rd_d = aq_rd_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_q <= CNT_ZERO;
      discard_q     <= CNT_ZERO;
      aq_wr_q       <= PTR_ZERO;
      aq_rd_q       <= PTR_ZERO;
      active_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        aq_mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      aq_wr_q       <= aq_wr_d;
      aq_rd_q       <= aq_rd_d;
      active_q      <= active_d;
      aq_mem_q      <= aq_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the fetch/response/decode flow.
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        instr_fault;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .instr_fault (instr_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: decoded entries waiting, addresses in flight, responses to drop.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        buf_q[$];
  logic [31:0] inflight_q[$];
  int          discard;
  logic        just_reset;
  logic [31:0] mem_pend[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 8);
  endfunction

  task automatic model_clear();
    buf_q.delete();
    inflight_q.delete();
    mem_pend.delete();
    discard    = 0;
    just_reset = 1'b1;
  endtask

  task automatic apply_reset(input int cycles, input logic stale_rv);
    reset       = 1'b1;
    flush       = 1'b0;
    imem_gnt    = 1'b1;
    instr_ready = 1'b0;
    imem_rvalid = stale_rv;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check_eq("rst_valid", instr_valid, 32'h0);
    check_eq("rst_instr", instr, 32'h0000_0013);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    check_eq("rst_req", imem_req, 32'h0);
    check_eq("rst_adv", pc_advance, 32'h0);
    check_eq("rst_fault", instr_fault, 32'h0);
    model_clear();
    repeat (cycles) @(posedge clk);
    #1;
    reset       = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model and clock.
  task automatic cycle(input logic fl, input logic gnt, input logic rv, input logic rdy);
    logic        exp_req;
    logic        exp_adv;
    logic        exp_valid;
    logic [31:0] a;
    ent_t        e;
    flush       = fl;
    imem_gnt    = gnt;
    instr_ready = rdy;
    imem_rvalid = rv;
    imem_rdata  = (mem_pend.size() != 0) ? mem_data(mem_pend[0]) : $urandom();
    #1;
    exp_req   = !fl && !just_reset && (inflight_q.size() + buf_q.size() < DEPTH);
    exp_adv   = exp_req && gnt;
    exp_valid = (buf_q.size() != 0);
    check_eq("imem_req", imem_req, exp_req);
    check_eq("pc_advance", pc_advance, exp_adv);
    check_eq("imem_addr", imem_addr, pc);
    check_eq("instr_valid", instr_valid, exp_valid);
    check_eq("instr", instr, exp_valid ? buf_q[0].instr : 32'h0000_0013);
    check_eq("instr_pc", instr_pc, exp_valid ? buf_q[0].pc : 32'h0);
    check_eq("instr_fault", instr_fault, 32'h0);

    if (rv && mem_pend.size() != 0) void'(mem_pend.pop_front());
    if (imem_req && imem_gnt) mem_pend.push_back(pc);

    if (exp_valid && rdy) void'(buf_q.pop_front());
    if (rv && inflight_q.size() != 0) begin
      a = inflight_q.pop_front();
      if (fl) begin
        discard = discard;
      end else if (discard > 0) begin
        discard--;
      end else begin
        e.pc    = a;
        e.instr = imem_rdata;
        buf_q.push_back(e);
      end
    end
    if (fl) begin
      buf_q.delete();
      discard = inflight_q.size();
    end
    if (exp_adv) inflight_q.push_back(pc);
    just_reset = 1'b0;

    @(posedge clk);
    #1;
    if (exp_adv) pc = pc + 32'd4;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    pc          = 32'h0;
    flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    discard     = 0;
    just_reset  = 1'b0;
    #1;

    // Reset for two cycles, then the first edge enables a request for pc 0.
    apply_reset(2, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("first_req", imem_req, 32'h1);
    check_eq("first_addr", imem_addr, 32'h0);

    // Single fetch: grant, then response one cycle later.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("fetch0_valid", instr_valid, 32'h1);
    check_eq("fetch0_instr", instr, 32'h0050_0093);
    check_eq("fetch0_pc", instr_pc, 32'h0);

    // Backpressure: with decode stalled, two slots fill and requests stop.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("full_req", imem_req, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("full_req2", imem_req, 32'h0);
    check_eq("full_head_pc", instr_pc, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("after_pop_req", imem_req, 32'h1);
    check_eq("after_pop_addr", imem_addr, 32'h8);
    check_eq("after_pop_pc", instr_pc, 32'h4);

    // Flush with two requests outstanding: late responses are dropped.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    pc = 32'h0000_0100;
    check_eq("flush_valid", instr_valid, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("drop1_valid", instr_valid, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("drop2_valid", instr_valid, 32'h0);
    check_eq("redirect_req", imem_req, 32'h1);
    check_eq("redirect_addr", imem_addr, 32'h0000_0100);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("redirect_pc", instr_pc, 32'h0000_0100);
    check_eq("redirect_instr", instr, mem_data(32'h0000_0100));

    // Reset with one buffered entry and one outstanding; the stale response is ignored.
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    apply_reset(2, 1'b1);
    pc = 32'h0;
    check_eq("post_rst_valid", instr_valid, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("post_rst_valid2", instr_valid, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned pc becomes a fault entry without a memory request.
    apply_reset(1, 1'b0);
    pc = 32'h0000_0006;
    flush = 1'b0;
    imem_gnt = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mis_req", imem_req, 32'h0);
    check_eq("mis_adv", pc_advance, 32'h1);
    @(posedge clk);
    #1;
    check_eq("mis_valid", instr_valid, 32'h1);
    check_eq("mis_fault", instr_fault, 32'h1);
    check_eq("mis_instr", instr, 32'h0000_0013);
    check_eq("mis_pc", instr_pc, 32'h0000_0006);
    apply_reset(1, 1'b0);
    pc = 32'h0;
`endif

    // Randomized traffic with occasional flushes and resets.
    for (int i = 0; i < 2500; i++) begin
      logic fl;
      if ($urandom_range(0, 299) == 0) begin
        apply_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
        pc = 32'($urandom_range(0, 255)) << 2;
      end else begin
        fl = ($urandom_range(0, 31) == 0);
        cycle(fl, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) < 6));
        if (fl) pc = 32'($urandom_range(0, 1023)) << 2;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of buffered {pc, instr} entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pc  input  32  current fetch address from ProgramCounter.
REQ-005 SHALL have port pc_advance  output  1  fetch of pc accepted this cycle; next_pc mux selects pc+4 only when high.
REQ-006 SHALL have port flush  input  1  redirect; discard everything in flight.
REQ-007 SHALL have ports imem_req output 1, imem_addr output 32, imem_gnt input 1  instruction-memory request handshake.
REQ-008 SHALL have ports imem_rvalid input 1, imem_rdata input 32  in-order memory response.
REQ-009 SHALL have ports instr_valid output 1, instr output 32, instr_pc output 32, instr_ready input 1  decode-side handshake.
REQ-010 SHALL have port instr_fault  output  1  head entry is a misaligned-fetch fault (constant 0 when macro absent).

Function
REQ-011 SHALL drive imem_addr = pc combinationally; imem_req = !flush && (outstanding + occupancy < DEPTH).
REQ-012 SHALL assert pc_advance = imem_req && imem_gnt; a request counts as issued only on that cycle.
REQ-013 SHALL track outstanding requests in a counter 0..DEPTH: +1 on issue, -1 on imem_rvalid, both in one cycle leaves it unchanged.
REQ-014 SHALL record pc of each issued request in a DEPTH-entry address queue and pair it with the matching in-order response.
REQ-015 SHALL write {addr, imem_rdata} into the buffer on imem_rvalid unless the response is being discarded (REQ-018); response-to-instr_valid latency is 1 cycle.
REQ-016 SHALL present the head entry on instr/instr_pc with instr_valid = occupancy != 0; pop on instr_valid && instr_ready; simultaneous push and pop at full keeps occupancy constant.
REQ-017 SHALL never overflow: REQ-011 reservation guarantees a slot for every outstanding response; imem_rvalid with outstanding == 0 is ignored.
REQ-018 SHALL on flush: clear buffer occupancy and pointers next edge, set a discard counter to outstanding (minus any response arriving that cycle), and drop the next discard-counter responses.
REQ-019 SHALL keep imem_req low in the flush cycle; requests resume the cycle after, against the new pc.
REQ-020 SHALL drive instr = 32'h00000013 (NOP) and instr_pc = 0 when instr_valid is low.
REQ-021 SHALL wrap buffer and address-queue pointers modulo DEPTH.

Reset
REQ-022 SHALL on reset clear occupancy, pointers, outstanding and discard counters: instr_valid=0, imem_req=0, pc_advance=0, instr=NOP, instr_pc=0, instr_fault=0.
REQ-023 SHALL treat reset asserted mid-transaction like flush, and additionally ignore imem_rvalid while reset is high.

Configuration
REQ-024 SHALL, with FETCH_MISALIGN_CHECK_EN defined, not request memory when pc[1:0] != 0; instead push {pc, NOP, fault=1} directly when a slot is free, assert pc_advance, and stop issuing until flush.
REQ-025 SHALL, without FETCH_MISALIGN_CHECK_EN, ignore pc[1:0] and tie instr_fault to 0.

Structure
REQ-026 SHALL place typedef fetch_entry_t {pc, instr, fault}, constant NOP_INSTR, and DEPTH default in package fetch_pkg.
REQ-027 SHALL implement storage in one sub-module fetch_fifo (generic DEPTH-entry fetch_entry_t FIFO with push/pop/full/empty/clear).

Verification
REQ-028 SHALL check: reset held 2 cycles, pc=0 -> instr_valid=0, instr=32'h00000013, imem_req=0; first edge after release imem_req=1, imem_addr=0.
REQ-029 SHALL check: gnt=1, rvalid one cycle later with rdata=32'h00500093 for pc=0 -> instr_valid=1, instr=32'h00500093, instr_pc=0 next cycle.
REQ-030 SHALL check: instr_ready=0, DEPTH=2, pc 0,4 granted -> imem_req drops to 0; third request only after one pop.
REQ-031 SHALL check: flush with 2 outstanding -> instr_valid=0 next cycle, both late responses dropped, next request addr = redirected pc 32'h00000100.
REQ-032 SHALL check (macro defined): pc=32'h00000006 -> no imem_req, instr_fault=1, instr=NOP, instr_pc=32'h00000006.
REQ-033 SHALL check: reset asserted with 1 outstanding and 1 buffered -> instr_valid=0 within 1 ns, no entry written by the stale response.
